// File: rtl/uart_tx_arbiter_pkg.sv
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter: FSM state encoding,
//   the largest supported requester count, and a one-hot to index helper.
//   No ports (package).
package uart_tx_arbiter_pkg;

  // Largest requester count the arbiter and its helpers are sized for.
  localparam int ARB_MAX_REQ = 8;
  // Index width able to address ARB_MAX_REQ requesters.
  localparam int ARB_IDX_W   = 3;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } arb_state_e;

  // Converts a one-hot (or all-zero) vector into the index of its set bit.
  // All-zero input yields index 0; the caller only uses the result while a
  // grant is held, so that case never matters.
  function automatic logic [ARB_IDX_W-1:0] onehot_to_idx(input logic [ARB_MAX_REQ-1:0] oh);
    logic [ARB_IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < ARB_MAX_REQ; i++) begin
      idx = idx | (ARB_IDX_W'(i) & {ARB_IDX_W{oh[i]}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester byte streams and the UART TX FIFO write port that
//   the arbiter sits between.
//   req_valid/req_data/req_last : requester -> arbiter (data packed, req i at [i*DATA_W +: DATA_W])
//   req_ready                   : arbiter -> requester
//   tx_full                     : uart -> arbiter
//   wr_uart/w_data              : arbiter -> uart
//   master modport: the requester/uart side; slave modport: the arbiter.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      tx_full;
  logic                      wr_uart;
  logic [DATA_W-1:0]         w_data;

  modport master (
    output req_valid, req_data, req_last, tx_full,
    input  req_ready, wr_uart, w_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_full,
    output req_ready, wr_uart, w_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_priority_pick.sv
// rr_priority_pick
//   Combinational round-robin pick: returns the first set request at or after
//   ptr, wrapping past the top back to index 0. Generic so other shared
//   resources can reuse it.
//   req       in  N      request vector
//   ptr       in  PTR_W  index with highest priority this round (must be < N)
//   winner    out N      one-hot winner, 0 when no request
//   any_valid out 1      at least one request present
module rr_priority_pick
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner,
  output logic             any_valid
);

  logic [N-1:0] win_hi;
  logic [N-1:0] win_lo;
  logic         hi_any;
  logic         lo_any;

  // Two scans: first valid at/after ptr (hi), and first valid overall (lo),
  // which is the wrapped choice when nothing at/after ptr is requesting.
  always_comb begin
    win_hi = '0;
    win_lo = '0;
    hi_any = 1'b0;
    lo_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      win_hi[i] = req[i] & (i >= int'(ptr)) & ~hi_any;
      hi_any    = hi_any | win_hi[i];
      win_lo[i] = req[i] & ~lo_any;
      lo_any    = lo_any | win_lo[i];
    end
    winner    = hi_any ? win_hi : win_lo;
    any_valid = |req;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART TX FIFO between NUM_REQ byte-stream requesters. Grants are
//   round-robin and held for a whole message; a watchdog takes the port back
//   from an owner that stops supplying bytes mid-message.
//   clk      in   clock
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport: req_valid/req_data/req_last in, req_ready out,
//            tx_full in, wr_uart/w_data out
//   grant    out  one-hot current owner, 0 when idle
//   busy     out  a message is in progress
//   abort    out  one-cycle pulse when the watchdog revokes a grant
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  uart_tx_arbiter_if.slave     bus,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 abort
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  arb_state_e         state_q,  state_d;
  logic [NUM_REQ-1:0] grant_q,  grant_d;
  logic               busy_q,   busy_d;
  logic               abort_q,  abort_d;
  logic [PTR_W-1:0]   ptr_q,    ptr_d;
  logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;

  logic [NUM_REQ-1:0] pick_win;
  logic               pick_any;
  logic               in_own;
  logic               own_valid;
  logic               own_last;
  logic [DATA_W-1:0]  own_data;
  logic               xfer;
  logic               wd_expired;
  logic [PTR_W-1:0]   ptr_next;
  int                 own_idx;

  rr_priority_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req       (bus.req_valid),
    .ptr       (ptr_q),
    .winner    (pick_win),
    .any_valid (pick_any)
  );

  // Owner-side view: valid/last/data of whichever requester holds the grant.
  always_comb begin
    in_own    = (state_q == ST_OWN);
    own_valid = |(bus.req_valid & grant_q);
    own_last  = |(bus.req_last & grant_q);
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      own_data = own_data | (bus.req_data[i*DATA_W +: DATA_W] & {DATA_W{grant_q[i]}});
    end
    xfer       = in_own & own_valid & ~bus.tx_full;
    wd_expired = (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    // Priority moves to the requester after the current owner, so an owner
    // re-requesting right away loses to anyone else already waiting.
    own_idx  = int'(onehot_to_idx(ARB_MAX_REQ'(grant_q)));
    ptr_next = (own_idx >= NUM_REQ - 1) ? '0 : PTR_W'(own_idx + 1);
  end

  // Next-state logic for arbitration FSM, priority pointer and watchdog.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    busy_d   = busy_q;
    abort_d  = 1'b0;
    ptr_d    = ptr_q;
    wd_cnt_d = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d  = pick_win;
          busy_d   = 1'b1;
          wd_cnt_d = '0;
          state_d  = ST_OWN;
        end else begin
          grant_d  = '0;
          busy_d   = 1'b0;
          wd_cnt_d = '0;
          state_d  = ST_IDLE;
        end
      end
      ST_OWN: begin
        if (xfer && own_last) begin
          grant_d  = '0;
          busy_d   = 1'b0;
          ptr_d    = ptr_next;
          wd_cnt_d = '0;
          state_d  = ST_IDLE;
        end else if (!own_valid) begin
          // Only an owner going silent counts; tx_full stalls never do.
          if (wd_expired) begin
            grant_d  = '0;
            busy_d   = 1'b0;
            abort_d  = 1'b1;
            ptr_d    = ptr_next;
            wd_cnt_d = '0;
            state_d  = ST_IDLE;
          end else begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
          end
        end else begin
          wd_cnt_d = '0;
        end
      end
      default: begin
        grant_d  = '0;
        busy_d   = 1'b0;
        wd_cnt_d = '0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // State registers; grant/busy/abort leave the block straight from flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
      ptr_q    <= '0;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
      ptr_q    <= ptr_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;
  assign abort = abort_q;

  // Zero-latency byte path: the owner's byte reaches the FIFO in the cycle it
  // is accepted. Gated by state so reset clears it without a clock edge.
  assign bus.req_ready = in_own ? (grant_q & {NUM_REQ{~bus.tx_full}}) : '0;
  assign bus.wr_uart   = xfer;
  assign bus.w_data    = xfer ? own_data : '0;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int TO = 8;

  logic          clk;
  logic          reset_n;
  logic [NR-1:0] grant;
  logic          busy;
  logic          abort;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] got_q [$];
  logic [7:0] exp_q [$];

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NR),
    .DATA_W      (DW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .grant   (grant),
    .busy    (busy),
    .abort   (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                       input logic [1:0] l, input logic full);
    bus.req_valid = v;
    bus.req_data  = {d1, d0};
    bus.req_last  = l;
    bus.tx_full   = full;
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge, advance.
  task automatic step(input string tag,
                      input logic [1:0] v, input logic [7:0] d1, input logic [7:0] d0,
                      input logic [1:0] l, input logic full,
                      input logic [1:0] eg, input logic [1:0] er, input logic ewr,
                      input logic [7:0] ed, input logic eab);
    drive(v, d1, d0, l, full);
    @(negedge clk);
    chk({tag, "/grant"}, 32'(grant), 32'(eg));
    chk({tag, "/busy"},  32'(busy),  32'(eg != 2'b00));
    chk({tag, "/ready"}, 32'(bus.req_ready), 32'(er));
    chk({tag, "/wr"},    32'(bus.wr_uart),   32'(ewr));
    chk({tag, "/wdata"}, 32'(bus.w_data),    32'(ed));
    chk({tag, "/abort"}, 32'(abort), 32'(eab));
    @(posedge clk);
    #1;
  endtask

  // Scoreboard capture of every byte written to the FIFO.
  always @(negedge clk) begin
    if (reset_n && bus.wr_uart) begin
      got_q.push_back(bus.w_data);
      chk("wr_while_full", 32'(bus.tx_full), 32'd0);
    end
  end

  initial begin
    logic [7:0] g;
    reset_n = 1'b0;
    drive(2'b00, 8'h00, 8'h00, 2'b00, 1'b0);
    @(negedge clk);
    chk("rst/grant", 32'(grant), 32'd0);
    chk("rst/busy",  32'(busy),  32'd0);
    chk("rst/abort", 32'(abort), 32'd0);
    chk("rst/wr",    32'(bus.wr_uart), 32'd0);
    chk("rst/ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Contention in IDLE: req0 wins first, then req1, then req0 again.
    step("t2a", 2'b11, 8'h43, 8'h41, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t2b", 2'b11, 8'h43, 8'h41, 2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 8'h41, 1'b0);
    step("t2c", 2'b11, 8'h43, 8'h42, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1, 8'h42, 1'b0);
    step("t2d", 2'b10, 8'h43, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t2e", 2'b10, 8'h43, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'h43, 1'b0);
    step("t2f", 2'b11, 8'h60, 8'h50, 2'b11, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t2g", 2'b11, 8'h60, 8'h50, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1, 8'h50, 1'b0);
    step("t2h", 2'b10, 8'h60, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t2i", 2'b10, 8'h60, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'h60, 1'b0);
    step("t2j", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // FIFO full for 5 cycles mid-message: no write, no ready, no abort.
    step("t3a", 2'b01, 8'h00, 8'h11, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t3b", 2'b01, 8'h00, 8'h11, 2'b00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h11, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step("t3full", 2'b01, 8'h00, 8'h22, 2'b00, 1'b1, 2'b01, 2'b00, 1'b0, 8'h00, 1'b0);
    end
    step("t3c", 2'b01, 8'h00, 8'h22, 2'b00, 1'b0, 2'b01, 2'b01, 1'b1, 8'h22, 1'b0);
    step("t3d", 2'b01, 8'h00, 8'h33, 2'b01, 1'b0, 2'b01, 2'b01, 1'b1, 8'h33, 1'b0);
    step("t3e", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // No interleave: req1 waits until req0's 4-byte message completes.
    step("t4a", 2'b01, 8'h00, 8'hA0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t4b", 2'b11, 8'hB0, 8'hA0, 2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 8'hA0, 1'b0);
    step("t4c", 2'b11, 8'hB0, 8'hA1, 2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 8'hA1, 1'b0);
    step("t4d", 2'b11, 8'hB0, 8'hA2, 2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 8'hA2, 1'b0);
    step("t4e", 2'b11, 8'hB0, 8'hA3, 2'b11, 1'b0, 2'b01, 2'b01, 1'b1, 8'hA3, 1'b0);
    step("t4f", 2'b10, 8'hB0, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t4g", 2'b10, 8'hB0, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'hB0, 1'b0);
    step("t4h", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // Watchdog: owner goes silent after one byte, abort after 8 silent cycles.
    step("t5a", 2'b11, 8'hD0, 8'hC0, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t5b", 2'b11, 8'hD0, 8'hC0, 2'b10, 1'b0, 2'b01, 2'b01, 1'b1, 8'hC0, 1'b0);
    for (int k = 0; k < TO; k++) begin
      step("t5wait", 2'b10, 8'hD0, 8'h00, 2'b10, 1'b0, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0);
    end
    step("t5abort", 2'b10, 8'hD0, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b1);
    step("t5next",  2'b10, 8'hD0, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'hD0, 1'b0);
    step("t5idle",  2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // Single requester, three one-byte messages: one idle cycle between writes.
    step("t6a", 2'b10, 8'hE1, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t6b", 2'b10, 8'hE1, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'hE1, 1'b0);
    step("t6c", 2'b10, 8'hE2, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t6d", 2'b10, 8'hE2, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'hE2, 1'b0);
    step("t6e", 2'b10, 8'hE3, 8'h00, 2'b10, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    step("t6f", 2'b10, 8'hE3, 8'h00, 2'b10, 1'b0, 2'b10, 2'b10, 1'b1, 8'hE3, 1'b0);
    step("t6g", 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // Reset mid-message: grant and write strobe drop without a clock edge.
    step("t1a", 2'b01, 8'h00, 8'hF0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);
    drive(2'b01, 8'h00, 8'hF0, 2'b00, 1'b0);
    @(negedge clk);
    chk("t1b/grant", 32'(grant), 32'd1);
    chk("t1b/wr",    32'(bus.wr_uart), 32'd1);
    chk("t1b/wdata", 32'(bus.w_data),  32'hF0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t1rst/grant", 32'(grant), 32'd0);
    chk("t1rst/busy",  32'(busy),  32'd0);
    chk("t1rst/wr",    32'(bus.wr_uart), 32'd0);
    chk("t1rst/ready", 32'(bus.req_ready), 32'd0);
    chk("t1rst/abort", 32'(abort), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step("t1c", 2'b01, 8'h00, 8'hF0, 2'b00, 1'b0, 2'b00, 2'b00, 1'b0, 8'h00, 1'b0);

    // Every byte reaches the FIFO exactly once, in order.
    exp_q = '{8'h41, 8'h42, 8'h43, 8'h50, 8'h60, 8'h11, 8'h22, 8'h33,
              8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hC0, 8'hD0,
              8'hE1, 8'hE2, 8'hE3, 8'hF0};
    chk("sb/count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 8'hxx;
      chk("sb/byte", 32'(g), 32'(exp_q[i]));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
